// File: rtl/axi_switch_traffic_monitor.sv
// rtl/axi_switch_traffic_monitor.sv - per-port AXI completion counting, handshake checks and pass/fail verdict
//
// Purpose: passively taps NUM_PORTS AXI interfaces and counts completed writes (B
// handshakes) and reads (R handshakes with rlast). It tracks outstanding bursts and
// flags protocol violations. An inactivity watchdog also runs. The combined
// registered verdict is presented as busy/done/fail.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_clear, i_start        synchronous clear to IDLE, IDLE->RUN strobe
//   i_aw*/i_w*/i_b*/i_ar*/i_r*  per-port channel taps, port p on bit p (bresp on [2p +: 2])
//   o_wr_done_cnt/o_rd_done_cnt per-port saturating completion counters [p*CNT_WIDTH +: CNT_WIDTH]
//   o_err                   per-port sticky flags [3p +: 3]: {ost under/overflow, bresp!=OKAY, valid drop}
//   o_timeout               sticky watchdog expiry
//   o_busy/o_done/o_fail    FSM in RUN / DONE / FAIL
module axi_switch_traffic_monitor #(
    parameter int NUM_PORTS      = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int OST_WIDTH      = 8,
    parameter int EXPECTED_TXNS  = 64,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clear,
    input  logic                           i_start,
    input  logic [NUM_PORTS-1:0]           i_awvalid,
    input  logic [NUM_PORTS-1:0]           i_awready,
    input  logic [NUM_PORTS-1:0]           i_wvalid,
    input  logic [NUM_PORTS-1:0]           i_wready,
    input  logic [NUM_PORTS-1:0]           i_wlast,
    input  logic [NUM_PORTS-1:0]           i_bvalid,
    input  logic [NUM_PORTS-1:0]           i_bready,
    input  logic [2*NUM_PORTS-1:0]         i_bresp,
    input  logic [NUM_PORTS-1:0]           i_arvalid,
    input  logic [NUM_PORTS-1:0]           i_arready,
    input  logic [NUM_PORTS-1:0]           i_rvalid,
    input  logic [NUM_PORTS-1:0]           i_rready,
    input  logic [NUM_PORTS-1:0]           i_rlast,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] o_wr_done_cnt,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] o_rd_done_cnt,
    output logic [3*NUM_PORTS-1:0]         o_err,
    output logic                           o_timeout,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_fail
);
    localparam int NCH = 5;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_EXP    = CNT_WIDTH'(EXPECTED_TXNS);
    localparam logic [OST_WIDTH-1:0] OST_MAX    = '1;
    localparam logic [OST_WIDTH-1:0] OST_ONE    = OST_WIDTH'(1);
    localparam logic [23:0]          WDOG_LIMIT = 24'(TIMEOUT_CYCLES);
    localparam logic [23:0]          WDOG_ONE   = 24'd1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

    state_t                              r_state;
    state_t                              w_next;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] r_wr_cnt;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] r_rd_cnt;
    logic [NUM_PORTS-1:0][OST_WIDTH-1:0] r_ost_wr;
    logic [NUM_PORTS-1:0][OST_WIDTH-1:0] r_ost_rd;
    logic [NUM_PORTS-1:0][2:0]           r_err;
    logic [23:0]                         r_wdog;
    logic                                r_timeout;
    logic [NCH*NUM_PORTS-1:0]            r_prev_valid;
    logic [NCH*NUM_PORTS-1:0]            r_prev_ready;

    logic [NCH*NUM_PORTS-1:0] w_valid;
    logic [NCH*NUM_PORTS-1:0] w_ready;
    logic [NCH*NUM_PORTS-1:0] w_drop;
    logic [NUM_PORTS-1:0]     w_aw_hs;
    logic [NUM_PORTS-1:0]     w_b_hs;
    logic [NUM_PORTS-1:0]     w_ar_hs;
    logic [NUM_PORTS-1:0]     w_rl_hs;
    logic [NUM_PORTS-1:0]     w_drop_port;
    logic                     w_any_hs;
    logic                     w_all_met;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_fail;
    logic                     w_unused;

    // Channel-major packing: channel c (AW,W,B,AR,R) of port p sits at bit c*NUM_PORTS+p.
    assign w_valid  = {i_rvalid, i_arvalid, i_bvalid, i_wvalid, i_awvalid};
    assign w_ready  = {i_rready, i_arready, i_bready, i_wready, i_awready};
    assign w_drop   = r_prev_valid & ~r_prev_ready & ~w_valid;
    assign w_any_hs = |(w_valid & w_ready);
    assign w_aw_hs  = i_awvalid & i_awready;
    assign w_b_hs   = i_bvalid & i_bready;
    assign w_ar_hs  = i_arvalid & i_arready;
    assign w_rl_hs  = i_rvalid & i_rready & i_rlast;
    // Write bursts are tracked on AW/B, so wlast is tapped but not needed.
    assign w_unused = ^i_wlast;

    always_comb begin
        w_drop_port = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int c = 0; c < NCH; c++)
                w_drop_port[p] = w_drop_port[p] | w_drop[c*NUM_PORTS+p];
    end

    always_comb begin
        w_all_met = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++)
            if (r_wr_cnt[p] < CNT_EXP || r_rd_cnt[p] < CNT_EXP ||
                r_ost_wr[p] != '0 || r_ost_rd[p] != '0)
                w_all_met = 1'b0;
    end

    // Previous-cycle samples keep tracking in every state so the first RUN cycle
    // compares against real history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_valid <= '0;
            r_prev_ready <= '0;
        end else begin
            r_prev_valid <= w_valid;
            r_prev_ready <= w_ready;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_ost_wr  <= '0;
            r_ost_rd  <= '0;
            r_err     <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (i_clear) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_ost_wr  <= '0;
            r_ost_rd  <= '0;
            r_err     <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_any_hs) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WDOG_ONE;
                if (r_wdog + WDOG_ONE >= WDOG_LIMIT)
                    r_timeout <= 1'b1;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_drop_port[p])
                    r_err[p][0] <= 1'b1;
                if (w_b_hs[p] && i_bresp[2*p +: 2] != 2'b00)
                    r_err[p][1] <= 1'b1;
                if (w_b_hs[p] && r_wr_cnt[p] != CNT_MAX)
                    r_wr_cnt[p] <= r_wr_cnt[p] + CNT_ONE;
                if (w_rl_hs[p] && r_rd_cnt[p] != CNT_MAX)
                    r_rd_cnt[p] <= r_rd_cnt[p] + CNT_ONE;
                // Simultaneous increment and decrement cancel and can never flag.
                if (w_aw_hs[p] && !w_b_hs[p]) begin
                    if (r_ost_wr[p] == OST_MAX) r_err[p][2] <= 1'b1;
                    else                        r_ost_wr[p] <= r_ost_wr[p] + OST_ONE;
                end else if (w_b_hs[p] && !w_aw_hs[p]) begin
                    if (r_ost_wr[p] == '0)      r_err[p][2] <= 1'b1;
                    else                        r_ost_wr[p] <= r_ost_wr[p] - OST_ONE;
                end
                if (w_ar_hs[p] && !w_rl_hs[p]) begin
                    if (r_ost_rd[p] == OST_MAX) r_err[p][2] <= 1'b1;
                    else                        r_ost_rd[p] <= r_ost_rd[p] + OST_ONE;
                end else if (w_rl_hs[p] && !w_ar_hs[p]) begin
                    if (r_ost_rd[p] == '0)      r_err[p][2] <= 1'b1;
                    else                        r_ost_rd[p] <= r_ost_rd[p] - OST_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Decisions use registered counters/flags, so the verdict lands one edge after them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN: begin
                if ((|r_err) || r_timeout) w_next = S_FAIL;
                else if (w_all_met)        w_next = S_DONE;
            end
            default: w_next = r_state;
        endcase
        if (i_clear) w_next = S_IDLE;
    end

    always_comb begin
        w_busy = (r_state == S_RUN);
        w_done = (r_state == S_DONE);
        w_fail = (r_state == S_FAIL);
    end

    assign o_wr_done_cnt = r_wr_cnt;
    assign o_rd_done_cnt = r_rd_cnt;
    assign o_err         = r_err;
    assign o_timeout     = r_timeout;
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_fail        = w_fail;
endmodule

// File: tb/tb_axi_switch_traffic_monitor.sv
// tb/tb_axi_switch_traffic_monitor.sv - self-checking bench for axi_switch_traffic_monitor
module tb_axi_switch_traffic_monitor;
    localparam int NP   = 2;
    localparam int CW   = 4;
    localparam int OW   = 2;
    localparam int EXP  = 4;
    localparam int TO   = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int OMAX = (1 << OW) - 1;
    localparam int AW = 0, W = 1, B = 2, AR = 3, R = 4;

    logic              clk = 1'b0;
    logic              rst, clear, start;
    logic [NP-1:0]     vld [5];
    logic [NP-1:0]     rdy [5];
    logic [NP-1:0]     wlast, rlast;
    logic [2*NP-1:0]   bresp;
    logic [NP*CW-1:0]  wr_cnt, rd_cnt;
    logic [3*NP-1:0]   err;
    logic              timeout, busy, done, fail;
    int                n_chk = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    axi_switch_traffic_monitor #(
        .NUM_PORTS(NP), .CNT_WIDTH(CW), .OST_WIDTH(OW),
        .EXPECTED_TXNS(EXP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_start(start),
        .i_awvalid(vld[AW]), .i_awready(rdy[AW]),
        .i_wvalid(vld[W]), .i_wready(rdy[W]), .i_wlast(wlast),
        .i_bvalid(vld[B]), .i_bready(rdy[B]), .i_bresp(bresp),
        .i_arvalid(vld[AR]), .i_arready(rdy[AR]),
        .i_rvalid(vld[R]), .i_rready(rdy[R]), .i_rlast(rlast),
        .o_wr_done_cnt(wr_cnt), .o_rd_done_cnt(rd_cnt), .o_err(err),
        .o_timeout(timeout), .o_busy(busy), .o_done(done), .o_fail(fail)
    );

    // Reference model: transaction-level bookkeeping in plain integers.
    typedef enum {M_IDLE, M_RUN, M_DONE, M_FAIL} mst_t;
    mst_t     m_st;
    int       m_wr [NP];
    int       m_rd [NP];
    int       m_ow [NP];
    int       m_or [NP];
    bit [2:0] m_err [NP];
    bit [4:0] m_pv [NP];
    bit [4:0] m_pr [NP];
    int       m_idle;
    bit       m_to;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_counts();
        for (int p = 0; p < NP; p++) begin
            m_wr[p] = 0; m_rd[p] = 0; m_ow[p] = 0; m_or[p] = 0; m_err[p] = 3'b000;
        end
        m_idle = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_counts();
        m_st = M_IDLE;
        for (int p = 0; p < NP; p++) begin
            m_pv[p] = 5'b0; m_pr[p] = 5'b0;
        end
    endtask

    task automatic model_update();
        mst_t ns;
        int   met, anyerr, anyhs, n;
        int   hs [5];
        if (rst) begin
            model_reset();
            return;
        end
        met    = 1;
        anyerr = int'(m_to);
        for (int p = 0; p < NP; p++) begin
            if (m_err[p] != 3'b000) anyerr = 1;
            if (m_wr[p] < EXP || m_rd[p] < EXP || m_ow[p] != 0 || m_or[p] != 0) met = 0;
        end
        ns = m_st;
        if (clear)                              ns = M_IDLE;
        else if (m_st == M_IDLE && start)       ns = M_RUN;
        else if (m_st == M_RUN && anyerr != 0)  ns = M_FAIL;
        else if (m_st == M_RUN && met != 0)     ns = M_DONE;
        if (clear) begin
            model_clear_counts();
        end else if (m_st == M_RUN) begin
            anyhs = 0;
            for (int p = 0; p < NP; p++) begin
                for (int c = 0; c < 5; c++) begin
                    hs[c] = int'(vld[c][p] & rdy[c][p]);
                    anyhs |= hs[c];
                    if (m_pv[p][c] && !m_pr[p][c] && !vld[c][p]) m_err[p][0] = 1'b1;
                end
                hs[R] = hs[R] & int'(rlast[p]);
                if (hs[B] != 0 && bresp[2*p +: 2] != 2'b00) m_err[p][1] = 1'b1;
                m_wr[p] = (m_wr[p] + hs[B] > CMAX) ? CMAX : m_wr[p] + hs[B];
                m_rd[p] = (m_rd[p] + hs[R] > CMAX) ? CMAX : m_rd[p] + hs[R];
                n = m_ow[p] + hs[AW] - hs[B];
                if (n < 0 || n > OMAX) begin m_err[p][2] = 1'b1; n = (n < 0) ? 0 : OMAX; end
                m_ow[p] = n;
                n = m_or[p] + hs[AR] - hs[R];
                if (n < 0 || n > OMAX) begin m_err[p][2] = 1'b1; n = (n < 0) ? 0 : OMAX; end
                m_or[p] = n;
            end
            if (anyhs != 0) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle >= TO) m_to = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 5; c++) begin
                m_pv[p][c] = vld[c][p];
                m_pr[p][c] = rdy[c][p];
            end
        m_st = ns;
    endtask

    task automatic check_all(input string tag);
        logic [NP*CW-1:0] ew, er;
        logic [3*NP-1:0]  ee;
        for (int p = 0; p < NP; p++) begin
            ew[p*CW +: CW] = CW'(m_wr[p]);
            er[p*CW +: CW] = CW'(m_rd[p]);
            ee[p*3 +: 3]   = m_err[p];
        end
        chk({tag, ".wr_cnt"},  64'(wr_cnt),  64'(ew));
        chk({tag, ".rd_cnt"},  64'(rd_cnt),  64'(er));
        chk({tag, ".err"},     64'(err),     64'(ee));
        chk({tag, ".timeout"}, 64'(timeout), 64'(m_to));
        chk({tag, ".busy"},    64'(busy),    64'(m_st == M_RUN));
        chk({tag, ".done"},    64'(done),    64'(m_st == M_DONE));
        chk({tag, ".fail"},    64'(fail),    64'(m_st == M_FAIL));
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        for (int c = 0; c < 5; c++) begin
            vld[c] = '0;
            rdy[c] = '0;
        end
        wlast = '0; rlast = '0; bresp = '0;
    endtask

    task automatic set_hs(input int p, input int c);
        vld[c][p] = 1'b1;
        rdy[c][p] = 1'b1;
    endtask

    task automatic restart();
        idle();
        clear = 1'b1; step("clr");
        clear = 1'b0; start = 1'b1; step("start");
        start = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < NP; p++) begin
            for (int c = 0; c < 5; c++) begin
                if (m_pv[p][c] && !m_pr[p][c] && $urandom_range(0, 31) != 0) vld[c][p] = 1'b1;
                else vld[c][p] = 1'($urandom_range(0, 1));
                rdy[c][p] = 1'($urandom_range(0, 1));
            end
            wlast[p] = 1'($urandom_range(0, 1));
            rlast[p] = 1'($urandom_range(0, 1));
            bresp[2*p +: 2] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        end
    endtask

    typedef struct {
        int       port;
        bit [4:0] hs;      // bit c: handshake on channel c (AW,W,B,AR,R)
        bit       rl;
        bit [1:0] resp;
        bit [2:0] e_err;
        int       e_wr;
        int       e_rd;
        bit       e_fail;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{0, 5'b00100, 1'b0, 2'b00, 3'b100, 1, 0, 1'b1}; // B without AW: underflow
        vt[1] = '{0, 5'b00100, 1'b0, 2'b10, 3'b110, 1, 0, 1'b1}; // SLVERR still counted
        vt[2] = '{1, 5'b00001, 1'b0, 2'b00, 3'b000, 0, 0, 1'b0}; // AW only
        vt[3] = '{1, 5'b10000, 1'b1, 2'b00, 3'b100, 0, 1, 1'b1}; // R last without AR
        vt[4] = '{0, 5'b10000, 1'b0, 2'b00, 3'b000, 0, 0, 1'b0}; // R beat without last
        vt[5] = '{1, 5'b11000, 1'b1, 2'b00, 3'b000, 0, 1, 1'b0}; // AR and R last together
        vt[6] = '{0, 5'b00101, 1'b0, 2'b01, 3'b010, 1, 0, 1'b1}; // AW+B, EXOKAY response
        vt[7] = '{0, 5'b00101, 1'b0, 2'b00, 3'b000, 1, 0, 1'b0}; // AW+B cancel
        vt[8] = '{1, 5'b00010, 1'b0, 2'b00, 3'b000, 0, 0, 1'b0}; // W only

        rst = 1'b1; clear = 1'b0; start = 1'b0;
        idle();
        step("reset");
        step("reset");
        chk("reset_wr", 64'(wr_cnt), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step("idle");

        // Reset mid-operation, then AW traffic without start stays uncounted.
        start = 1'b1; step("rs_start"); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(); set_hs(0, B); set_hs(1, AW); step("rs_traffic");
        end
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        chk("rst_async_wr", 64'(wr_cnt), 64'd0);
        step("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(); set_hs(0, AW); set_hs(1, AW); step("rs_idle_aw");
        end
        chk("rs_idle_wr", 64'(wr_cnt), 64'd0);
        chk("rs_idle_err", 64'(err), 64'd0);
        chk("rs_idle_busy", 64'({busy, done, fail}), 64'd0);
        idle(); step("rs_idle_end");

        // Table vectors: one event cycle right after start.
        for (int i = 0; i < 9; i++) begin
            restart();
            for (int c = 0; c < 5; c++) if (vt[i].hs[c]) set_hs(vt[i].port, c);
            rlast[vt[i].port] = vt[i].rl;
            bresp[2*vt[i].port +: 2] = vt[i].resp;
            step("vec_evt");
            chk($sformatf("vec%0d_err", i), 64'(err[3*vt[i].port +: 3]), 64'(vt[i].e_err));
            chk($sformatf("vec%0d_wr", i), 64'(wr_cnt[CW*vt[i].port +: CW]), 64'(vt[i].e_wr));
            chk($sformatf("vec%0d_rd", i), 64'(rd_cnt[CW*vt[i].port +: CW]), 64'(vt[i].e_rd));
            idle();
            step("vec_post");
            chk($sformatf("vec%0d_fail", i), 64'(fail), 64'(vt[i].e_fail));
        end

        // Pass: 4 single-beat writes then reads per iteration on both ports.
        restart();
        for (int k = 0; k < 4; k++) begin
            idle(); for (int p = 0; p < NP; p++) set_hs(p, AW); step("pass_aw");
            idle(); for (int p = 0; p < NP; p++) begin set_hs(p, W); wlast[p] = 1'b1; end
            step("pass_w");
            idle(); for (int p = 0; p < NP; p++) begin set_hs(p, B); set_hs(p, AR); end
            step("pass_b_ar");
            idle(); for (int p = 0; p < NP; p++) begin set_hs(p, R); rlast[p] = 1'b1; end
            step("pass_r");
        end
        chk("pass_wr", 64'(wr_cnt), 64'h44);
        chk("pass_rd", 64'(rd_cnt), 64'h44);
        chk("pass_done_early", 64'(done), 64'd0);
        idle();
        step("pass_wait");
        chk("pass_done", 64'(done), 64'd1);
        chk("pass_fail", 64'(fail), 64'd0);
        step("pass_hold");
        chk("pass_done_hold", 64'(done), 64'd1);

        // Valid drop on port 1 AR.
        restart();
        vld[AR][1] = 1'b1;
        step("drop_hold");
        chk("drop_err_pre", 64'(err), 64'd0);
        idle();
        step("drop_evt");
        chk("drop_err", 64'(err[3]), 64'd1);
        chk("drop_fail_pre", 64'(fail), 64'd0);
        step("drop_next");
        chk("drop_fail", 64'(fail), 64'd1);
        set_hs(1, R); rlast[1] = 1'b1;
        step("drop_frozen");
        chk("drop_rd_frozen", 64'(rd_cnt), 64'd0);

        // Outstanding overflow at OST_WIDTH=2.
        restart();
        for (int i = 0; i < 4; i++) begin
            idle(); set_hs(0, AW); step("ovf_aw");
            if (i == 2) chk("ovf_err_3rd", 64'(err[2]), 64'd0);
            if (i == 3) chk("ovf_err_4th", 64'(err[2]), 64'd1);
        end
        idle();
        step("ovf_post");
        chk("ovf_fail", 64'(fail), 64'd1);

        // Watchdog expiry, then clear.
        restart();
        set_hs(0, AW);
        step("to_aw");
        idle();
        for (int i = 1; i <= 16; i++) begin
            step("to_idle");
            if (i == 15) chk("to_early", 64'(timeout), 64'd0);
            if (i == 16) begin
                chk("to_set", 64'(timeout), 64'd1);
                chk("to_fail_early", 64'(fail), 64'd0);
            end
        end
        step("to_post");
        chk("to_fail", 64'(fail), 64'd1);
        clear = 1'b1;
        step("to_clear");
        clear = 1'b0;
        chk("clr_outputs", 64'({wr_cnt, rd_cnt, err, timeout, busy, done, fail}), 64'd0);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 25; ep++) begin
            restart();
            for (int cyc = 0; cyc < 40; cyc++) begin
                rand_inputs();
                step("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
